// File: rtl/regfile_port_ctrl.sv
// Core-side port controller for a 32x32 SRAM register file: operand reads with
// write forwarding, a pending-write scoreboard for RAW/WAW stalls, and x0 semantics.
module regfile_port_ctrl #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rq_valid,
  output logic            rq_ready,
  input  logic [AW-1:0]   rq_rs1,
  input  logic [AW-1:0]   rq_rs2,
  input  logic            rq_dst_en,
  input  logic [AW-1:0]   rq_dst,
  output logic            rs_valid,
  output logic [XLEN-1:0] rs_a,
  output logic [XLEN-1:0] rs_b,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [AW-1:0]   rf_ra,
  output logic [AW-1:0]   rf_rb,
  output logic [AW-1:0]   rf_rd,
  output logic            rf_we,
  output logic [XLEN-1:0] rf_di,
  input  logic [XLEN-1:0] rf_qa,
  input  logic [XLEN-1:0] rf_qb
);

  logic [NREG-1:0] pend_q, pend_d;

  // h1 holds the write of the previous cycle, h2 the one before that; together
  // they cover the two cycles the array needs before a write becomes readable.
  logic            h1_v_q, h1_v_d, h2_v_q, h2_v_d;
  logic [AW-1:0]   h1_rd_q, h1_rd_d, h2_rd_q, h2_rd_d;
  logic [XLEN-1:0] h1_data_q, h1_data_d, h2_data_q, h2_data_d;

  logic            fire_q, fire_d;
  logic [AW-1:0]   s1_q, s1_d, s2_q, s2_d;
  logic [XLEN-1:0] rs_a_q, rs_a_d, rs_b_q, rs_b_d;

  logic            wb_fire, wb_wr, rq_fire;
  logic            busy_rs1, busy_rs2, busy_dst;
  logic            resp_v;

  function automatic logic [XLEN-1:0] pick_operand(
    input logic [AW-1:0]   s,
    input logic            h1_v,
    input logic [AW-1:0]   h1_rd,
    input logic [XLEN-1:0] h1_data,
    input logic            h2_v,
    input logic [AW-1:0]   h2_rd,
    input logic [XLEN-1:0] h2_data,
    input logic [XLEN-1:0] q
  );
    if (s == '0)                   return '0;
    else if (h1_v && h1_rd == s)   return h1_data;
    else if (h2_v && h2_rd == s)   return h2_data;
    else                           return q;
  endfunction

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the logic leaves a value unassigned and no latch is inferred.
    wb_ready = !rst;
    wb_fire  = wb_valid && wb_ready;
    wb_wr    = wb_fire && (wb_rd != '0);

    rf_we = wb_wr;
    rf_rd = wb_wr ? wb_rd : '0;
    rf_di = wb_wr ? wb_data : '0;
    rf_ra = rq_rs1;
    rf_rb = rq_rs2;

    // A write-back landing this cycle resolves the hazard it would otherwise cause.
    busy_rs1 = (rq_rs1 != '0) && pend_q[rq_rs1] && !(wb_fire && wb_rd == rq_rs1);
    busy_rs2 = (rq_rs2 != '0) && pend_q[rq_rs2] && !(wb_fire && wb_rd == rq_rs2);
    busy_dst = rq_dst_en && (rq_dst != '0) && pend_q[rq_dst]
               && !(wb_fire && wb_rd == rq_dst);

    rq_ready = !rst && !busy_rs1 && !busy_rs2 && !busy_dst;
    rq_fire  = rq_valid && rq_ready;

    // Clear then set, so a reservation in the same cycle as its old producer's
    // write-back keeps the register pending for the new producer.
    pend_d = pend_q;
    if (wb_fire) pend_d[wb_rd] = 1'b0;
    if (rq_fire && rq_dst_en && rq_dst != '0) pend_d[rq_dst] = 1'b1;
    pend_d[0] = 1'b0;

    h1_v_d    = wb_wr;
    h1_rd_d   = wb_rd;
    h1_data_d = wb_data;
    h2_v_d    = h1_v_q;
    h2_rd_d   = h1_rd_q;
    h2_data_d = h1_data_q;

    fire_d = rq_fire;
    s1_d   = rq_rs1;
    s2_d   = rq_rs2;

    resp_v = fire_q && !rst;
    rs_a_d = resp_v ? pick_operand(s1_q, h1_v_q, h1_rd_q, h1_data_q,
                                   h2_v_q, h2_rd_q, h2_data_q, rf_qa) : rs_a_q;
    rs_b_d = resp_v ? pick_operand(s2_q, h1_v_q, h1_rd_q, h1_data_q,
                                   h2_v_q, h2_rd_q, h2_data_q, rf_qb) : rs_b_q;

    rs_valid = resp_v;
    rs_a     = rs_a_d;
    rs_b     = rs_b_d;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      h1_v_q <= 1'b0;
      h2_v_q <= 1'b0;
      fire_q <= 1'b0;
      rs_a_q <= '0;
      rs_b_q <= '0;
    end else begin
      pend_q <= pend_d;
      h1_v_q <= h1_v_d;
      h2_v_q <= h2_v_d;
      fire_q <= fire_d;
      rs_a_q <= rs_a_d;
      rs_b_q <= rs_b_d;
    end
  end

  // NOTE: payload registers are qualified by their valid bits, so they carry no
  // reset; keeping them in a separate block avoids reset-gated enables on them.
  always_ff @(posedge clk) begin
    h1_rd_q   <= h1_rd_d;
    h1_data_q <= h1_data_d;
    h2_rd_q   <= h2_rd_d;
    h2_data_q <= h2_data_d;
    s1_q      <= s1_d;
    s2_q      <= s2_d;
  end

endmodule

// File: doc/regfile_port_ctrl.md
Name: regfile_port_ctrl

Overview:
- Core-side initiator for the SRAM-based 32x32 register file.
- Accepts operand-read requests from decode and write-back requests from the WB stage, then drives the file's ra/rb/rd/we/di pins.
- Returns operands one cycle after acceptance, forwarding writes the array has not yet absorbed.
- Holds a pending-write scoreboard and stalls decode on RAW and WAW hazards. The array has no hardwired x0, so this block enforces x0 semantics.

Parameters:
XLEN, 32, data width
NREG, 32, register count (address width log2(NREG) = 5)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
rq_valid  input  1  decode read request valid
rq_ready  output  1  request accepted when valid&&ready
rq_rs1  input  5  source A index
rq_rs2  input  5  source B index
rq_dst_en  input  1  request reserves a destination
rq_dst  input  5  destination index to mark pending
rs_valid  output  1  operand response valid (one-cycle pulse)
rs_a  output  32  operand A
rs_b  output  32  operand B
wb_valid  input  1  write-back valid
wb_ready  output  1  write-back accepted
wb_rd  input  5  write-back destination
wb_data  input  32  write-back data
rf_ra  output  5  register file read address A
rf_rb  output  5  register file read address B
rf_rd  output  5  register file write address
rf_we  output  1  register file write enable
rf_di  output  32  register file write data
rf_qa  input  32  register file read data A (valid one cycle after rf_ra)
rf_qb  input  32  register file read data B

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset clears:
  - all pend bits;
  - both history entries (valid=0);
  - rs_valid, rs_a, rs_b;
  - rf_we, rf_rd, rf_di.
- During rst, rq_ready=0 and wb_ready=0.
- Scoreboard: pend[31:1] registers. pend[0] is constant 0.
- Write path:
  - wb_ready=1 whenever not in reset. wb_fire = wb_valid && wb_ready.
  - In a wb_fire cycle with wb_rd!=0, drive rf_we=1, rf_rd=wb_rd, rf_di=wb_data combinationally. Otherwise rf_we=0 and rf_rd/rf_di=0.
  - wb_fire with wb_rd=0 is accepted and discarded: no rf_we, no history entry, no pend change.
  - wb_fire clears pend[wb_rd]. A write to a non-pending register is legal and is written normally.
- Write history:
  - h1 = {valid, rd, data} of the write in the previous cycle. h2 = h1 delayed one cycle.
  - A write presented in cycle N is visible in rf_qa/rf_qb only for reads presented in cycle N+2 or later.
- Hazard check for request fields:
  - A source is busy when pend[rs] && !(wb_fire && wb_rd==rs). rs=0 is never busy.
  - The destination is busy when rq_dst_en && rq_dst!=0 && pend[rq_dst] && !(wb_fire && wb_rd==rq_dst).
- rq_ready = !rst && !busy(rs1) && !busy(rs2) && !busy(dst). rq_ready depends combinationally on rq_* and wb_*.
- Read path:
  - rf_ra=rq_rs1 and rf_rb=rq_rs2, always combinational.
  - On rq_fire in cycle N, rs_valid=1 in cycle N+1 for exactly one cycle. Back-to-back fires give back-to-back responses.
- Operand select at N+1, per source s, registered from cycle N (s, fire):
  1. s==0 gives 0.
  2. Same-cycle write (wb in N with rd==s) gives that data. This comes from h1 at N+1.
  3. Otherwise h2 hit (write in N-1) gives h2 data.
  4. Otherwise rf_q*.
  - Priority is h1 over h2.
- Reservation: on rq_fire with rq_dst_en && rq_dst!=0, set pend[rq_dst] at the clock edge.
  - If a wb_fire to the same index occurs in the same cycle, set wins: the register stays pending for the new producer.
- rs_a/rs_b hold their last value when rs_valid=0.
- Reset mid-operation: any in-flight response is dropped (rs_valid=0 the next cycle) and the history is invalidated. The register array contents are untouched.

Test Plan:
1. Reset, then wb x5=0xDEADBEEF. Two cycles later, request rs1=5, rs2=0 -> next cycle rs_valid=1, rs_a=0xDEADBEEF (from array), rs_b=0.
2. wb x7=0x11 in cycle N and request rs1=7 in cycle N. Then wb x7=0x22 at N+1 with request rs1=7 at N+1 -> rs_a=0x11 at N+1 and 0x22 at N+2 (forwarded; array bypass verified).
3. Request dst_en=1, dst=3. Next cycle request rs1=3 -> rq_ready=0 held until wb x3=0x99 fires. Request accepted that same cycle -> following cycle rs_a=0x99.
4. wb x0=0xFFFFFFFF, then request rs1=0 -> rf_we stays 0 throughout, rs_a=0. Also request dst_en=1, dst=0 -> pend unaffected, next request rs1=0 not stalled.
5. With pend[4]=1, request dst=4 (WAW) while wb x4 fires the same cycle -> accepted, pend[4]=1 afterwards. A later rs1=4 request stalls until the second wb x4.
6. Fire a request, assert rst the next cycle -> rs_valid=0, rq_ready=0, all pend cleared. After release, a request for a previously pending register is accepted immediately.
